img_line_sequencer: RTL and testbench

//  Frame-level flow controller in front of the 4-line-buffer pixel window stage.
//  - Accepts an 8-bit pixel stream from upstream (valid/ready).
//  - Forwards it as i_pixel/i_pixel_valid to the window stage, one line at a time, only when a free line buffer exists.
//  - Frees a buffer on each line-consumed pulse (window stage o_interrupt).
//  - Resets the window stage at frame start and signals frame completion.

---
 rtl/img_line_sequencer_pkg.sv | 27 ++
 rtl/img_line_sequencer_if.sv | 28 ++
 rtl/img_line_sequencer.sv | 171 +++++++++++++++++
 tb/tb_img_line_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_line_sequencer_pkg.sv
// =============================================================================
// img_line_sequencer_pkg : shared state encoding and window constants
// Revision 1.0
// =============================================================================
`default_nettype none

package img_line_sequencer_pkg;

  // Rows in the downstream pixel window; each output line needs this many input lines.
  localparam int WIN_SIZE = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  // Output lines produced by the window stage for a frame of the given height.
  function automatic int frame_used_target(input int lines);
    return lines - (WIN_SIZE - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/img_line_sequencer_if.sv
// =============================================================================
// img_line_sequencer_if : upstream pixel stream plus window-stage link
// Revision 1.0
// =============================================================================
`default_nettype none

interface img_line_sequencer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] pixel;
  logic       pixel_valid;
  logic       line_done;
  logic       img_rst;

  // master: the sequencer; slave: the surrounding source/window stage
  modport master (
    input  s_data, s_valid, line_done,
    output s_ready, pixel, pixel_valid, img_rst
  );

  modport slave (
    output s_data, s_valid, line_done,
    input  s_ready, pixel, pixel_valid, img_rst
  );
endinterface

`default_nettype wire

// File: rtl/img_line_sequencer.sv
// =============================================================================
// img_line_sequencer : credit-based line flow controller ahead of the window stage
// Revision 1.0
// =============================================================================
`default_nettype none

module img_line_sequencer
  import img_line_sequencer_pkg::*;
#(
  parameter int LINE_W    = 512,
  parameter int IMG_LINES = 512,
  parameter int NUM_BUF   = 4
) (
  input  wire logic                         i_clk,
  input  wire logic                         i_rst_n,
  input  wire logic                         i_start,
  input  wire logic                         i_abort,
  img_line_sequencer_if.master              bus,
  output logic                              o_busy,
  output logic                              o_frame_done,
  output logic [$clog2(NUM_BUF+1)-1:0]      o_credit,
  output logic                              o_err
);

  localparam int CW  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int SW  = $clog2(IMG_LINES + 1);
  localparam int CRW = $clog2(NUM_BUF + 1);

  localparam logic [CW-1:0]  C_COL_LAST    = CW'(LINE_W - 1);
  localparam logic [SW-1:0]  C_SENT_MAX    = SW'(IMG_LINES);
  localparam logic [SW-1:0]  C_USED_END    = SW'(frame_used_target(IMG_LINES));
  localparam logic [CRW-1:0] C_CREDIT_FULL = CRW'(NUM_BUF);

  seq_state_e     state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [SW-1:0]  sent_q, sent_d;
  logic [SW-1:0]  used_q, used_d;
  logic [CRW-1:0] credit_q, credit_d;
  logic [7:0]     pixel_q, pixel_d;
  logic           pixel_valid_q, pixel_valid_d;
  logic           img_rst_q, img_rst_d;
  logic           err_q, err_d;

  logic           s_ready;
  logic           xfer;
  logic           line_end;
  logic           in_frame;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      sent_q        <= '0;
      used_q        <= '0;
      credit_q      <= C_CREDIT_FULL;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      img_rst_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      sent_q        <= sent_d;
      used_q        <= used_d;
      credit_q      <= credit_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      img_rst_q     <= img_rst_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    sent_d        = sent_q;
    used_d        = used_q;
    credit_d      = credit_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    img_rst_d     = 1'b0;
    err_d         = err_q;

    // Abort is folded into ready so no pixel slips through on the abort cycle.
    s_ready  = (state_q == ST_STREAM) && (credit_q != '0) && (sent_q < C_SENT_MAX) && !i_abort;
    xfer     = bus.s_valid && s_ready;
    line_end = xfer && (col_q == C_COL_LAST);
    in_frame = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

    if (i_abort) begin
      state_d   = ST_IDLE;
      col_d     = '0;
      sent_d    = '0;
      used_d    = '0;
      credit_d  = C_CREDIT_FULL;
      img_rst_d = 1'b1;
    end else begin
      if (xfer) begin
        pixel_d       = bus.s_data;
        pixel_valid_d = 1'b1;
        col_d         = line_end ? '0 : col_q + 1'b1;
      end
      if (line_end) begin
        sent_d = sent_q + 1'b1;
      end

      // A freed buffer and a newly filled one in the same cycle cancel out.
      if (in_frame) begin
        if (bus.line_done) begin
          used_d = used_q + 1'b1;
        end
        if (bus.line_done && !line_end) begin
          if (credit_q == C_CREDIT_FULL) begin
            err_d = 1'b1;
          end else begin
            credit_d = credit_q + 1'b1;
          end
        end else if (line_end && !bus.line_done) begin
          credit_d = credit_q - 1'b1;
        end
      end else if (bus.line_done) begin
        err_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d   = ST_CLR;
            img_rst_d = 1'b1;
          end
        end
        ST_CLR: begin
          col_d    = '0;
          sent_d   = '0;
          used_d   = '0;
          credit_d = C_CREDIT_FULL;
          state_d  = ST_STREAM;
        end
        ST_STREAM: begin
          if (line_end && (sent_q == C_SENT_MAX - 1'b1)) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (used_q == C_USED_END) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready     = s_ready;
  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.img_rst     = img_rst_q;

  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = (state_q == ST_DONE);
  assign o_credit     = credit_q;
  assign o_err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_img_line_sequencer.sv
// =============================================================================
// tb_img_line_sequencer : directed + randomized bench with a frame-level model
// Revision 1.0
// =============================================================================
`default_nettype none

module tb_img_line_sequencer;

  localparam int LINE_W    = 8;
  localparam int IMG_LINES = 6;
  localparam int NUM_BUF   = 4;
  localparam int TOTAL     = LINE_W * IMG_LINES;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       busy;
  logic       frame_done;
  logic [2:0] credit;
  logic       err;

  img_line_sequencer_if bus ();

  img_line_sequencer #(
    .LINE_W   (LINE_W),
    .IMG_LINES(IMG_LINES),
    .NUM_BUF  (NUM_BUF)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .bus         (bus),
    .o_busy      (busy),
    .o_frame_done(frame_done),
    .o_credit    (credit),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int dut_px      = 0;
  int fd_cnt      = 0;

  // Frame-level model: phase 0 idle, 1 clearing, 2 active (stream/drain), 3 done
  int         m_phase;
  int         m_px;
  int         m_used;
  int         m_credit;
  bit         m_err;
  bit         m_pv;
  bit         m_rst;
  logic [7:0] m_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase  = 0;
    m_px     = 0;
    m_used   = 0;
    m_credit = NUM_BUF;
    m_err    = 1'b0;
    m_pv     = 1'b0;
    m_rst    = 1'b0;
    m_pix    = 8'h00;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pixel"},       bus.pixel, 0);
    chk({tag, "_pixel_valid"}, bus.pixel_valid, 0);
    chk({tag, "_img_rst"},     bus.img_rst, 0);
    chk({tag, "_frame_done"},  frame_done, 0);
    chk({tag, "_err"},         err, 0);
    chk({tag, "_credit"},      credit, NUM_BUF);
    chk({tag, "_busy"},        busy, 0);
    chk({tag, "_ready"},       bus.s_ready, 0);
  endtask

  // One clock: drive inputs, check all outputs against the model, advance the model.
  task automatic cycle(input bit v, input logic [7:0] d, input bit ld, input bit st, input bit ab);
    bit rdy, xf, le, dn;
    bus.s_valid   = v;
    bus.s_data    = d;
    bus.line_done = ld;
    start         = st;
    abort         = ab;
    #1;
    rdy = (m_phase == 2) && (m_px < TOTAL) && (m_credit > 0) && !ab;
    chk("s_ready",     bus.s_ready, rdy);
    chk("pixel_valid", bus.pixel_valid, m_pv);
    if (m_pv) chk("pixel", bus.pixel, m_pix);
    chk("credit",      credit, m_credit);
    chk("busy",        busy, m_phase != 0);
    chk("frame_done",  frame_done, m_phase == 3);
    chk("err",         err, m_err);
    chk("img_rst",     bus.img_rst, m_rst);
    if (bus.pixel_valid === 1'b1) dut_px++;
    if (frame_done === 1'b1) fd_cnt++;

    xf = v && rdy;
    if (ab) begin
      m_phase  = 0;
      m_px     = 0;
      m_used   = 0;
      m_credit = NUM_BUF;
      m_rst    = 1'b1;
      m_pv     = 1'b0;
    end else begin
      m_rst = (m_phase == 0) && st;
      m_pv  = xf;
      if (xf) m_pix = d;
      case (m_phase)
        0: begin
          if (ld) m_err = 1'b1;
          if (st) m_phase = 1;
        end
        1: begin
          if (ld) m_err = 1'b1;
          m_px     = 0;
          m_used   = 0;
          m_credit = NUM_BUF;
          m_phase  = 2;
        end
        2: begin
          dn = (m_px == TOTAL) && (m_used == IMG_LINES - 2);
          le = xf && ((m_px % LINE_W) == LINE_W - 1);
          if (xf) m_px++;
          if (ld) m_used++;
          if (ld && !le && m_credit == NUM_BUF) m_err = 1'b1;
          else m_credit = m_credit + int'(ld) - int'(le);
          if (dn) m_phase = 3;
        end
        default: begin
          if (ld) m_err = 1'b1;
          m_phase = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Full frame with a window-stage-like line_done source (an output line after 3 input lines).
  task automatic run_frame(input bit rnd, input int budget, input string tag);
    int fd0, p0;
    bit v, ld, st;
    fd0 = fd_cnt;
    p0  = dut_px;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < budget && fd_cnt == fd0; i++) begin
      v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld = ((m_px / LINE_W) - 2 > m_used) && (rnd ? ($urandom_range(0, 2) == 0) : 1'b1);
      st = (m_phase == 3);
      cycle(v, 8'($urandom), ld, st, 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk({tag, "_frame_done_cnt"}, fd_cnt - fd0, 1);
    chk({tag, "_pixels"}, dut_px - p0, TOTAL);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int p0, fd0;
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'h00;
    bus.line_done = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;

    // Frame with no line_done: four buffers fill, then stall
    p0 = dut_px;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t1_img_rst", bus.img_rst, 1);
    for (int i = 0; i < 45; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    chk("t1_pixels", dut_px - p0, 32);
    chk("t1_credit", credit, 0);
    chk("t1_ready", bus.s_ready, 0);

    // Free buffers one at a time, then drain to frame end
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    chk("t2_pixels_40", dut_px - p0, 40);
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    chk("t2_pixels_48", dut_px - p0, 48);
    chk("t2_drain_busy", busy, 1);
    fd0 = fd_cnt;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && fd_cnt == fd0; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t2_frame_done_cnt", fd_cnt - fd0, 1);
    chk("t2_busy_end", busy, 0);

    // Random valid gaps and random line_done timing, start pulsed during DONE
    run_frame(1'b1, 800, "t3a");
    run_frame(1'b1, 800, "t3b");

    // line_done coincident with a line-end at credit 1
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3 * LINE_W + LINE_W - 1; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    chk("t4_credit_before", credit, 1);
    cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    chk("t4_credit_after", credit, 1);
    chk("t4_ready_after", bus.s_ready, 1);
    cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);

    // Abort at column 3 of line 2, then a clean deterministic frame
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LINE_W + 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    chk("t6_busy", busy, 0);
    chk("t6_img_rst", bus.img_rst, 1);
    chk("t6_credit", credit, NUM_BUF);
    run_frame(1'b0, 200, "t6");

    // Asynchronous reset in the middle of a frame
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    fd0 = fd_cnt;
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    chk_reset("arst");
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("arst_no_frame_done", fd_cnt - fd0, 0);

    // line_done with a full credit pool, then while idle
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5_err_clear", err, 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t5_err_set", err, 1);
    chk("t5_credit_hold", credit, NUM_BUF);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5_err_sticky", err, 1);
    chk("t5_credit_idle", credit, NUM_BUF);
    chk("t5_busy_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
